quad_position_ctrl: RTL and testbench

Closed-loop position controller built around the quadrature encoder path of the motor board. It decodes the raw encoder channels into a signed position count and accepts target-position commands over a valid/ready handshake. It sequences the motor-driver enable and direction outputs until the position settles inside a deadband. It detects stalled motion and latches a fault. It sits between the command/register interface and the H-bridge driver pins, and runs on the 100 MHz system clock.

---
 rtl/quad_pkg.sv | 31 +++
 rtl/quad_position_ctrl_if.sv | 11 +
 rtl/quad_step_decoder.sv | 37 +++
 rtl/quad_position_ctrl.sv | 98 +++++++++
 tb/tb_quad_position_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/quad_pkg.sv
// Shared types and defaults for the quadrature position controller.
package quad_pkg;

   localparam int unsigned POS_W_DEF         = 16;
   localparam int unsigned DEADBAND_DEF      = 2;
   localparam int unsigned STALL_CYCLES_DEF  = 1000000;
   localparam int unsigned SETTLE_CYCLES_DEF = 100000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE   = 2'd1,
      SETTLE = 2'd2,
      FAULT  = 2'd3
   } state_t;

   localparam logic STEP_UP = 1'b1;
   localparam logic STEP_DN = 1'b0;

   // Position of an {A,B} pair along the forward sequence 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] gray_idx(input logic [1:0] ab);
      logic [1:0] idx;
      case (ab)
         2'b00:   idx = 2'd0;
         2'b10:   idx = 2'd1;
         2'b11:   idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/quad_position_ctrl_if.sv
// Target-command valid/ready channel into the position controller.
interface quad_position_ctrl_if #(
   parameter int unsigned POS_W = quad_pkg::POS_W_DEF
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [POS_W-1:0] cmd_target;

   modport master (output cmd_valid, output cmd_target, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_target, output cmd_ready);
endinterface

// File: rtl/quad_step_decoder.sv
// Synchronises raw A/B and emits a one-cycle step strobe with its direction.
module quad_step_decoder
   import quad_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   output logic step,
   output logic step_up
);

   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] hist;
   logic [1:0] diff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         hist  <= '0;
      end else begin
         sync1 <= {a, b};
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   // +1 along the sequence is forward, -1 reverse; a jump of 2 is illegal.
   always_comb begin
      diff    = gray_idx(sync2) - gray_idx(hist);
      step    = (diff == 2'd1) || (diff == 2'd3);
      step_up = (diff == 2'd1) ? STEP_UP : STEP_DN;
   end

endmodule

// File: rtl/quad_position_ctrl.sv
// Encoder-tracked position servo: move until inside the deadband, settle, verify.
module quad_position_ctrl
   import quad_pkg::*;
#(
   parameter int unsigned POS_W         = POS_W_DEF,
   parameter int unsigned DEADBAND      = DEADBAND_DEF,
   parameter int unsigned STALL_CYCLES  = STALL_CYCLES_DEF,
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 A,
   input  logic                 B,
   quad_position_ctrl_if.slave  cmd,
   input  logic                 clear_fault,
   output logic                 motor_en,
   output logic                 motor_dir,
   output logic [POS_W-1:0]     position,
   output logic                 busy,
   output logic                 done,
   output logic                 fault
);

   localparam int unsigned STALL_W  = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
   localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [STALL_W-1:0]  STALL_LAST  = STALL_W'(STALL_CYCLES - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [POS_W-1:0]    DB          = POS_W'(DEADBAND);

   state_t              state;
   state_t              state_nx;
   logic                step;
   logic                step_up;
   logic [POS_W-1:0]    target_q;
   logic [POS_W-1:0]    err;
   logic [POS_W-1:0]    abs_err;
   logic                on_target;
   logic                dir_fwd;
   logic                settle_end;
   logic [STALL_W-1:0]  stall_cnt;
   logic [SETTLE_W-1:0] settle_cnt;

   quad_step_decoder u_dec (
      .clk     (clk),
      .rst     (rst),
      .a       (A),
      .b       (B),
      .step    (step),
      .step_up (step_up)
   );

   // Modular difference read as signed gives the shortest way round the wrap.
   assign err        = target_q - position;
   assign abs_err    = err[POS_W-1] ? ('0 - err) : err;
   assign on_target  = (abs_err <= DB);
   assign dir_fwd    = !err[POS_W-1] && (err != '0);
   assign settle_end = (settle_cnt == SETTLE_LAST);

   assign cmd.cmd_ready = (state == IDLE);
   assign motor_en      = (state == MOVE);
   assign busy          = (state == MOVE) || (state == SETTLE);
   assign fault         = (state == FAULT);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (cmd.cmd_valid) state_nx = MOVE;
         MOVE: begin
            if (on_target)                               state_nx = SETTLE;
            else if (!step && (stall_cnt == STALL_LAST)) state_nx = FAULT;
         end
         SETTLE: if (settle_end) state_nx = on_target ? IDLE : MOVE;
         FAULT:  if (clear_fault) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         position   <= '0;
         target_q   <= '0;
         motor_dir  <= 1'b0;
         done       <= 1'b0;
         stall_cnt  <= '0;
         settle_cnt <= '0;
      end else begin
         state <= state_nx;
         if (step) position <= (step_up == STEP_UP) ? position + 1'b1 : position - 1'b1;
         if ((state == IDLE) && cmd.cmd_valid) target_q <= cmd.cmd_target;
         if (state == MOVE) motor_dir <= dir_fwd;
         done       <= (state == SETTLE) && settle_end && on_target;
         stall_cnt  <= ((state != MOVE) || step) ? '0 : stall_cnt + 1'b1;
         settle_cnt <= ((state == SETTLE) && !settle_end) ? settle_cnt + 1'b1 : '0;
      end
   end

endmodule

// File: tb/tb_quad_position_ctrl.sv
// Directed bench: decoder latency, closed-loop moves, overshoot, stall fault, wrap, reset.
module tb_quad_position_ctrl;
   import quad_pkg::*;

   localparam int unsigned POS_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             A = 1'b0;
   logic             B = 1'b0;
   logic             clear_fault = 1'b0;
   logic             motor_en, motor_dir, busy, done, fault;
   logic [POS_W-1:0] position;

   int checks = 0;
   int errors = 0;
   int enc_idx = 0;

   int               done_cnt;
   logic             dir_seen;
   logic             settle_seen;
   logic [POS_W-1:0] settle_pos;
   logic             ready_at_done;

   quad_position_ctrl_if #(.POS_W(POS_W)) cmd_if ();

   quad_position_ctrl #(
      .POS_W(POS_W), .DEADBAND(2), .STALL_CYCLES(50), .SETTLE_CYCLES(10)
   ) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .cmd(cmd_if), .clear_fault(clear_fault),
      .motor_en(motor_en), .motor_dir(motor_dir), .position(position),
      .busy(busy), .done(done), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_enc(input int idx);
      enc_idx = idx & 3;
      case (enc_idx)
         0:       {A, B} = 2'b00;
         1:       {A, B} = 2'b10;
         2:       {A, B} = 2'b11;
         default: {A, B} = 2'b01;
      endcase
   endtask

   task automatic step_enc(input logic fwd);
      set_enc(fwd ? enc_idx + 1 : enc_idx + 3);
   endtask

   task automatic issue(input logic [POS_W-1:0] tgt);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_target = tgt;
      tick(1);
      cmd_if.cmd_valid  = 1'b0;
   endtask

   // Motor model: one encoder step every 4 cycles while enabled.
   task automatic servo(input int max_cyc);
      int cnt = 0;
      int post = -1;
      done_cnt = 0; dir_seen = 1'b0; settle_seen = 1'b0; settle_pos = '0; ready_at_done = 1'b0;
      while (cnt < max_cyc && post != 0) begin
         tick(1);
         cnt++;
         if (cnt == 2) dir_seen = motor_dir;
         if (motor_en && (cnt % 4 == 0)) step_enc(motor_dir);
         if (busy && !motor_en && !settle_seen) begin
            settle_seen = 1'b1;
            settle_pos  = position;
         end
         if (done) begin
            done_cnt++;
            ready_at_done = cmd_if.cmd_ready;
            if (post < 0) post = 3;
         end else if (post > 0) post--;
      end
   endtask

   initial begin
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_target = '0;
      tick(3);
      rst = 1'b0;
      tick(1);
      check_eq("rst_pos", position, 0);
      check_eq("rst_ready", cmd_if.cmd_ready, 1);
      check_eq("rst_en", motor_en, 0);
      check_eq("rst_dir", motor_dir, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_fault", fault, 0);

      // decoder latency and x4 counting
      step_enc(1'b1);
      tick(2);
      check_eq("lat_2", position, 0);
      tick(1);
      check_eq("lat_3", position, 1);
      tick(1);
      for (int i = 0; i < 7; i++) begin step_enc(1'b1); tick(4); end
      check_eq("fwd8", position, 8);
      for (int i = 0; i < 8; i++) begin step_enc(1'b0); tick(4); end
      check_eq("rev8", position, 0);

      // both channels change together: ignored, history still follows
      set_enc(2);
      tick(5);
      check_eq("illegal", position, 0);
      step_enc(1'b1);
      tick(4);
      check_eq("post_illegal", position, 1);
      step_enc(1'b0);
      tick(4);
      check_eq("post_illegal_back", position, 0);

      // closed loop to 20
      issue(16'd20);
      check_eq("hs_ready", cmd_if.cmd_ready, 0);
      check_eq("hs_en", motor_en, 1);
      servo(300);
      check_eq("m20_dir", dir_seen, 1);
      check_eq("m20_settle", settle_seen, 1);
      check_eq("m20_settle_pos", settle_pos, 18);
      check_eq("m20_done_cnt", done_cnt, 1);
      check_eq("m20_ready_at_done", ready_at_done, 1);
      check_eq("m20_pos", position, 18);

      // overshoot to 23 during SETTLE for target 20
      step_enc(1'b1);
      tick(2);
      step_enc(1'b1);
      issue(16'd20);
      step_enc(1'b1);
      tick(2);
      check_eq("os_settle_en", motor_en, 0);
      check_eq("os_settle_busy", busy, 1);
      step_enc(1'b1);
      tick(2);
      step_enc(1'b1);
      tick(9);
      check_eq("os_pos", position, 23);
      check_eq("os_remove_en", motor_en, 1);
      check_eq("os_remove_dir", motor_dir, 0);
      servo(300);
      check_eq("os_done_cnt", done_cnt, 1);
      check_eq("os_final_pos", position, 22);

      // frozen encoder: stall fault after 50 MOVE cycles
      issue(16'd100);
      tick(49);
      check_eq("stall_49_fault", fault, 0);
      check_eq("stall_49_en", motor_en, 1);
      check_eq("stall_dir", motor_dir, 1);
      tick(1);
      check_eq("stall_50_fault", fault, 1);
      check_eq("stall_50_en", motor_en, 0);
      check_eq("stall_50_busy", busy, 0);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_target = 16'd5;
      tick(3);
      check_eq("fault_hold", fault, 1);
      check_eq("fault_ready", cmd_if.cmd_ready, 0);
      cmd_if.cmd_valid = 1'b0;
      clear_fault = 1'b1;
      tick(1);
      clear_fault = 1'b0;
      check_eq("clr_fault", fault, 0);
      check_eq("clr_ready", cmd_if.cmd_ready, 1);

      // asynchronous reset mid-move
      issue(16'd100);
      tick(3);
      check_eq("pre_rst_en", motor_en, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_en", motor_en, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_pos", position, 0);
      set_enc(0);
      tick(2);
      rst = 1'b0;
      tick(4);
      check_eq("post_rst_pos", position, 0);
      check_eq("post_rst_ready", cmd_if.cmd_ready, 1);

      // reverse below zero, then forward back across the wrap
      issue(16'hFFFD);
      servo(300);
      check_eq("neg_dir", dir_seen, 0);
      check_eq("neg_done_cnt", done_cnt, 1);
      check_eq("neg_pos", position, 16'hFFFF);
      issue(16'h0002);
      servo(300);
      check_eq("wrap_dir", dir_seen, 1);
      check_eq("wrap_done_cnt", done_cnt, 1);
      check_eq("wrap_pos", position, 0);

      // 0x8001 from 0 is shorter going down
      issue(16'h8001);
      tick(2);
      check_eq("half_dir", motor_dir, 0);
      tick(50);
      check_eq("half_fault", fault, 1);
      clear_fault = 1'b1;
      tick(1);
      clear_fault = 1'b0;
      check_eq("half_clr", cmd_if.cmd_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
